// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: word-organised RAM with byte/halfword/word access,
// configurable wait states, two-cycle ERROR for illegal transfers.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTCLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [ADDR_WIDTH-1:0] waddr_p0;
  logic [3:0]            mask_p0;
  logic                  write_p0;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  req_legal;
  logic [3:0]            req_mask;
  logic [ADDR_WIDTH-1:0] req_waddr;
  logic                  commit;
  logic                  rd_load;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]           rd_word;
  logic [31:0]           rd_data;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTCLOCK, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    is_legal = 1'b1;
      3'd1:    is_legal = ~off[0];
      3'd2:    is_legal = (off == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    lane_mask = 4'b0001 << off;
      3'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    merge_lanes = res;
  endfunction

  assign req_legal = is_legal(HSIZE, HADDR[1:0]);
  assign req_mask  = lane_mask(HSIZE, HADDR[1:0]);
  assign req_waddr = HADDR[ADDR_WIDTH+1:2];

  // A new address phase can only be taken while this slave is ready.
  assign accept = HSEL & HREADY & HTRANS[1] &
                  ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR2));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        HRESP = (state == S_ERR2);
        if (accept) begin
          if (!req_legal) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 4'd0) state_nxt = S_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write data is only valid in the final data-phase cycle; reset drops it.
  assign commit = (state == S_DONE) & write_p0 & ~HRESET;

  // Entering DONE straight from an accept (zero waits) reads the live address.
  always_comb begin
    rd_load = 1'b0;
    rd_addr = waddr_p0;
    if (state_nxt == S_DONE) begin
      if (accept) begin
        rd_load = ~HWRITE;
        rd_addr = req_waddr;
      end else begin
        rd_load = ~write_p0;
      end
    end
  end

  assign rd_word = mem[rd_addr];
  assign rd_data = (commit && (waddr_p0 == rd_addr)) ? merge_lanes(rd_word, HWDATA, mask_p0)
                                                     : rd_word;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      write_p0 <= 1'b0;
      HRDATA   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) write_p0 <= HWRITE;
      if (rd_load) HRDATA <= rd_data;
    end
  end

  // Address-phase capture feeding the data phase
  always_ff @(posedge HCLK) begin
    if (accept) begin
      waddr_p0 <= req_waddr;
      mask_p0  <= req_mask;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_p0[i]) mem[waddr_p0][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: two instances (1 and 0 wait states)
// driven with directed and random AHB traffic against a word-array model.
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit done [2];

  typedef struct {
    bit          err;
    bit          rd;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  task automatic check(input string name, input int ln, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s lane%0d: got 0x%08h expected 0x%08h at %0t", name, ln, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WS = (g == 0) ? 1 : 0;

    logic        rst, hsel, hwrite, hmastlock, hreadyout, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
      .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTCLOCK(hmastlock), .HREADY(hreadyout), .HWDATA(hwdata),
      .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp)
    );

    exp_t        q [$];
    bit   [31:0] mdl [int];
    logic [31:0] nxt_wd;

    // One address phase; returns just after the edge that ends it.
    task automatic beat(input logic [1:0] tr, input bit sel, input bit wr,
                        input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, input bit upd);
      bit   rdy;
      int   n, nb, key;
      bit   legal;
      exp_t e;
      bit [31:0] w;
      hsel   = sel;
      htrans = tr;
      haddr  = addr;
      hwrite = wr;
      hsize  = size;
      hburst = 3'($urandom);
      hprot  = 4'($urandom);
      hmastlock = 1'($urandom);
      hwdata = nxt_wd;
      n = 0;
      do begin
        @(negedge clk);
        rdy = hreadyout;
        @(posedge clk);
        #1;
        n++;
      end while (!rdy && n < 40);
      if (!rdy) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout lane%0d: got HREADYOUT=0 for %0d cycles expected 1", g, n);
      end
      nxt_wd = 32'($urandom);
      if (rdy && sel && tr[1]) begin
        nb    = (size <= 3'd2) ? (1 << size) : 1;
        legal = (size <= 3'd2) && ((int'(addr[1:0]) % nb) == 0);
        key   = int'(addr[11:2]);
        e.err = !legal; e.rd = 1'b0; e.chk = 1'b0; e.data = 32'd0;
        if (legal && wr) begin
          nxt_wd = wd;
          if (upd) begin
            w = mdl.exists(key) ? mdl[key] : 32'd0;
            for (int k = int'(addr[1:0]); k < int'(addr[1:0]) + nb; k++) w[8*k +: 8] = wd[8*k +: 8];
            mdl[key] = w;
          end
        end else if (legal) begin
          e.rd   = 1'b1;
          e.chk  = mdl.exists(key);
          e.data = mdl.exists(key) ? mdl[key] : 32'd0;
        end
        q.push_back(e);
      end
    endtask

    task automatic idle(input int n);
      repeat (n) beat(2'b00, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
    endtask

    task automatic wr_w(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      beat(2'b10, 1'b1, 1'b1, a, s, d, 1'b1);
    endtask

    task automatic rd_w(input logic [31:0] a);
      beat(2'b10, 1'b1, 1'b0, a, 3'd2, 32'd0, 1'b1);
    endtask

    // Monitor: every data phase ending with HREADYOUT=1 retires one expectation.
    bit   pending = 1'b0;
    int   lowcnt = 0;
    logic first_resp = 1'b0;
    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        if (pending && q.size() > 0) void'(q.pop_front());
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (!hreadyout) begin
            lowcnt++;
            if (lowcnt == 1) first_resp = hresp;
          end else begin
            pending = 1'b0;
            if (q.size() == 0) begin
              check("unexpected_response", g, 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              check("resp", g, {31'd0, hresp}, {31'd0, e.err});
              check("wait_cycles", g, lowcnt, e.err ? 1 : WS);
              if (e.err) check("err_first_resp", g, {31'd0, first_resp}, 32'd1);
              if (e.rd && e.chk && !e.err) check("rdata", g, hrdata, e.data);
            end
          end
        end
        if (hsel && hreadyout && htrans[1]) begin
          pending = 1'b1;
          lowcnt  = 0;
        end
      end
    end

    initial begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'd0;
      nxt_wd = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_hreadyout", g, {31'd0, hreadyout}, 32'd1);
      check("rst_hresp", g, {31'd0, hresp}, 32'd0);
      check("rst_hrdata", g, hrdata, 32'd0);

      wr_w(32'h10, 3'd2, 32'hDEADBEEF);
      rd_w(32'h10);
      idle(2);

      wr_w(32'h20, 3'd2, 32'h00000000);
      wr_w(32'h21, 3'd0, 32'h0000AB00);
      wr_w(32'h22, 3'd1, 32'hCDEF0000);
      rd_w(32'h20);
      idle(2);

      wr_w(32'h30, 3'd2, 32'h12345678);
      rd_w(32'h30);
      idle(2);

      wr_w(32'h40, 3'd2, 32'h55AA55AA);
      idle(1);
      wr_w(32'h42, 3'd2, 32'hFFFFFFFF);
      wr_w(32'h40, 3'd3, 32'hFFFFFFFF);
      wr_w(32'h41, 3'd1, 32'hFFFFFFFF);
      rd_w(32'h40);
      idle(2);

      wr_w(32'h50, 3'd2, 32'h11111111);
      idle(2);
      beat(2'b10, 1'b1, 1'b1, 32'h50, 3'd2, 32'h22222222, 1'b0);
      hwdata = 32'h22222222;
      hsel = 1'b0; htrans = 2'b00; rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midreset_hreadyout", g, {31'd0, hreadyout}, 32'd1);
      check("midreset_hresp", g, {31'd0, hresp}, 32'd0);
      idle(1);
      rd_w(32'h50);
      idle(2);

      for (int i = 0; i < 16; i++) wr_w(32'h100 + 32'(4 * i), 3'd2, 32'($urandom));
      for (int i = 0; i < 300; i++) begin
        case ($urandom_range(0, 9))
          0:       tr = 2'b00;
          1:       tr = 2'b01;
          default: tr = {1'b1, 1'($urandom)};
        endcase
        sz = 3'($urandom_range(0, 5));
        if (sz > 3'd3) sz = 3'd2;
        a = {20'($urandom), 12'(32'h100 + $urandom_range(0, 63))};
        beat(tr, $urandom_range(0, 9) != 0, 1'($urandom), a, sz, 32'($urandom), 1'b1);
        if ($urandom_range(0, 7) == 0) idle(1);
      end
      idle(3);
      check("queue_empty", g, q.size(), 32'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: lanes done %0d/%0d expected 1/1", done[0], done[1]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
